aes_sbox_pipe: RTL and testbench
================================

// Module: aes_sbox_pipe
//
// PURPOSE
// Multi-lane, pipelined AES byte-substitution unit for the round datapath.
// Each beat carries LANES bytes. Every byte passes through the forward S-box
// (SubBytes) or, per beat, the inverse S-box (InvSubBytes). A valid/ready
// handshake with backpressure lets one unit serve encrypt and decrypt rounds.
// This block replaces per-byte combinational S-box instances in the round logic.
//
// PARAMETERS
// LANES   4   bytes per beat, 1..16 (16 = full AES state)
// INV_EN  1   1: inverse table built and in_inv honoured; 0: forward only
//
// PORTS
// clk        in   1          rising-edge clock
// rst_n      in   1          asynchronous active-low reset
// in_valid   in   1          input beat valid
// in_ready   out  1          unit can accept a beat this cycle
// in_data    in   8*LANES    lane i = bits [8i+7:8i]
// in_inv     in   1          1 = inverse S-box for this beat (ignored if INV_EN=0)
// out_valid  out  1          output beat valid
// out_ready  in   1          downstream accepts the output beat
// out_data   out  8*LANES    substituted bytes, lane order preserved
// out_inv    out  1          in_inv captured with this beat (0 if INV_EN=0)
// busy       out  1          s1_valid | out_valid
//
// BEHAVIOUR
// - Reset (async assert, sync release): s1_valid=0, out_valid=0,
//   out_data=0, out_inv=0, busy=0. Any in-flight beats are dropped, not flushed.
// - Two-stage pipeline:
//   - S1 registers in_data and in_inv.
//   - S2 (the output stage) registers the table lookup of the S1 bytes.
// - Transfer rules:
//   - Input transfer = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
// - Advance rules:
//   - adv2 = ~out_valid | out_ready. S2 loads S1 contents; out_valid <= s1_valid.
//   - adv1 = ~s1_valid | adv2. S1 loads input; s1_valid <= in_valid.
//   - in_ready = adv1. This is combinational from out_ready, which is permitted.
// - Latency and throughput:
//   - Latency is exactly 2 cycles when unstalled: accepted on edge N, out_valid high after edge N+1.
//   - Throughput is 1 beat/cycle.
//   - Stalls squeeze out bubbles: an empty stage fills even while a later stage is held.
// - Stall: while out_valid & ~out_ready, out_data and out_inv stay stable.
//   No beat is lost or duplicated. Capacity is 2 beats.
// - Lookup:
//   - Each lane is independent.
//   - Forward table is the FIPS-197 S-box. Inverse table is its exact inverse.
//   - The mode travels with the beat, so mixed fwd/inv beats back-to-back are legal.
// - in_valid deasserted: the S1 bubble propagates. out_valid drops only after
//   the last valid beat has transferred.
// - Simultaneous in/out transfer on a full pipe is legal: both stages shift and occupancy is unchanged.
// - in_data and in_inv are sampled only on an input transfer. X on them while
//   in_valid=0 must not reach out_data when out_valid=1.
//
// TESTING
// 1. Fwd, LANES=4: in_data=32'h53_01_00_FF, in_inv=0
//    -> 2 cycles later out_data=32'hED_7C_63_16, out_inv=0.
// 2. Inv: in_data=32'hED_7C_63_16, in_inv=1 -> out_data=32'h53_01_00_FF, out_inv=1.
// 3. Exhaustive round trip: every byte 00..FF, fwd then inv through the unit
//    -> original byte returned. Fwd beat 00..FF matches the FIPS-197 table.
// 4. Backpressure: stream 8 beats; hold out_ready=0 for 5 cycles mid-stream
//    -> in_ready=0 after 2 beats buffered, out_data stable, all 8 beats in order.
// 5. Alternating in_inv 0/1 every cycle with out_ready=1 -> 1 beat/cycle, correct mode per beat.
// 6. Assert rst_n low with 2 beats in flight -> out_valid=0 and busy=0
//    immediately (async). After release, the first new beat appears 2 cycles after accept.

Source files
------------

// File: rtl/aes_sbox_pipe_if.sv
// Valid/ready stream bundle for the pipelined AES byte-substitution unit.
// The unit connects through the slave modport; its producer/consumer use master.
interface aes_sbox_pipe_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic               out_inv;
  logic               busy;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_inv, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_inv, busy
  );
endinterface

// File: rtl/aes_sbox_pipe.sv
// Two-stage, multi-lane AES SubBytes/InvSubBytes unit with valid/ready backpressure.
// S1 holds the raw beat; S2 holds the substituted beat and drives the output.
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_sbox_pipe_if.slave bus
);
  localparam int W     = 8 * LANES;
  localparam bit InvOn = (INV_EN != 0);

  // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    if (InvOn && inv) return gf_inv(inv_affine(b));
    else              return affine(gf_inv(b));
  endfunction

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_data_q,  s1_data_d;
  logic         s1_inv_q,   s1_inv_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         out_inv_q,   out_inv_d;
  logic         adv1, adv2;
  logic [W-1:0] sub_data;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_inv_d    = s1_inv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_inv_d   = out_inv_q;
    sub_data    = '0;

    adv2 = ~out_valid_q | bus.out_ready;
    adv1 = ~s1_valid_q | adv2;

    for (int i = 0; i < LANES; i++) begin
      sub_data[8*i +: 8] = sub_byte(s1_data_q[8*i +: 8], s1_inv_q);
    end

    // Payload registers load only with a real beat, so idle-cycle X never propagates.
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.in_data;
        s1_inv_d  = bus.in_inv & InvOn;
      end
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sub_data;
        out_inv_d  = s1_inv_q;
      end
    end
  end

  // NOTE: payload registers are reset too, because out_data/out_inv must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_inv_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so both stages shift from the same pre-edge state.
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_inv_q    <= s1_inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_inv_q   <= out_inv_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_inv   = out_inv_q;
  assign bus.busy      = s1_valid_q | out_valid_q;
endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: FIPS-197 vectors, exhaustive round trip,
// backpressure, mixed modes, bubbles and asynchronous reset with beats in flight.
module tb_aes_sbox_pipe;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_sbox_pipe_if #(.LANES(LANES)) bus ();

  aes_sbox_pipe #(.LANES(LANES), .INV_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] inv_tab [256];

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [31:0] dout;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] src_data[$];
  logic        src_inv[$];
  logic [31:0] exp_data[$];
  logic        exp_inv[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++)
      r[8*j +: 8] = inv ? inv_tab[d[8*j +: 8]] : fwd_tab[d[8*j +: 8]];
    return r;
  endfunction

  task automatic push_beat(input logic [31:0] d, input logic inv, input logic [31:0] e);
    src_data.push_back(d);
    src_inv.push_back(inv);
    exp_data.push_back(e);
    exp_inv.push_back(inv);
  endtask

  // Drives the queued beats and scores every cycle: in_ready, busy, stall
  // stability and in-order output. exp_cycles > 0 also checks the cycle count.
  task automatic run_stream(input int stall_start, input int stall_len, input int gap,
                            input int exp_cycles, input string tag);
    int          cyc = 0;
    int          occ = 0;
    int          si  = 0;
    bit          rdy, send, in_x, out_x;
    bit          stalled_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_inv  = 1'b0;
    got_q.delete();
    while (exp_data.size() > 0 && cyc < 400) begin
      @(negedge clk);
      rdy  = !(cyc >= stall_start && cyc < stall_start + stall_len);
      send = (si < src_data.size()) && !(gap > 0 && (cyc % gap) == gap - 1);
      bus.out_ready = rdy;
      bus.in_valid  = send;
      if (send) begin
        bus.in_data = src_data[si];
        bus.in_inv  = src_inv[si];
      end else begin
        bus.in_data = 'x;
        bus.in_inv  = 1'bx;
      end
      #1;
      check({tag, " in_ready"}, bus.in_ready, (occ < 2) || rdy);
      check({tag, " busy"}, bus.busy, occ > 0);
      if (stalled_prev) begin
        check({tag, " held valid"}, bus.out_valid, 1'b1);
        check({tag, " held data"}, bus.out_data, prev_data);
        check({tag, " held inv"}, bus.out_inv, prev_inv);
      end
      out_x = bus.out_valid && rdy;
      in_x  = send && bus.in_ready;
      if (out_x) begin
        check({tag, " data"}, bus.out_data, exp_data.pop_front());
        check({tag, " inv"}, bus.out_inv, exp_inv.pop_front());
        got_q.push_back(bus.out_data);
      end
      if (in_x) si++;
      occ = occ + int'(in_x) - int'(out_x);
      stalled_prev = bus.out_valid && !rdy;
      prev_data    = bus.out_data;
      prev_inv     = bus.out_inv;
      cyc++;
    end
    check({tag, " beats left"}, exp_data.size(), 0);
    if (exp_cycles > 0) check({tag, " cycles"}, cyc, exp_cycles);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check({tag, " drained busy"}, bus.busy, 1'b0);
    check({tag, " drained valid"}, bus.out_valid, 1'b0);
    src_data.delete();
    src_inv.delete();
    exp_data.delete();
    exp_inv.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    vecs[0] = '{32'h5301_00FF, 1'b0, 32'hED7C_6316};
    vecs[1] = '{32'hED7C_6316, 1'b1, 32'h5301_00FF};
    vecs[2] = '{32'h0001_0203, 1'b0, 32'h637C_777B};
    vecs[3] = '{32'h637C_777B, 1'b1, 32'h0001_0203};
    vecs[4] = '{32'h1020_3040, 1'b0, 32'hCAB7_0409};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 32'h7D7D_7D7D};
    vecs[6] = '{32'h0000_0000, 1'b1, 32'h5252_5252};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_inv    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 32'h0);
    check("reset out_inv", bus.out_inv, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat vectors: latency 2 means the beat pops on the third sample.
    for (int v = 0; v < 7; v++) begin
      push_beat(vecs[v].din, vecs[v].inv, vecs[v].dout);
      run_stream(1000, 0, 0, 3, $sformatf("vec%0d", v));
    end

    // Exhaustive forward pass against the FIPS-197 table.
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < LANES; j++) d[8*j +: 8] = 8'(4*k + j);
      push_beat(d, 1'b0, model(d, 1'b0));
    end
    run_stream(1000, 0, 0, 66, "fwd_all");

    // Feed the unit's own forward output back through the inverse path.
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < LANES; j++) d[8*j +: 8] = 8'(4*k + j);
      if (k < got_q.size()) push_beat(got_q[k], 1'b1, d);
    end
    run_stream(1000, 0, 0, 66, "roundtrip");

    // Backpressure: 5-cycle stall mid-stream, mixed modes.
    for (int k = 0; k < 8; k++) begin
      d = 32'h1357_9BDF ^ (32'h0101_0101 * k);
      push_beat(d, k[0], model(d, k[0]));
    end
    run_stream(3, 5, 0, 0, "stall");

    // Alternating mode every beat at full rate.
    for (int k = 0; k < 16; k++) begin
      d = 32'hA5C3_0F96 + 32'h0404_0404 * k;
      push_beat(d, k[0], model(d, k[0]));
    end
    run_stream(1000, 0, 0, 18, "alt");

    // Input bubbles (X payload while idle) combined with a short stall.
    for (int k = 0; k < 10; k++) begin
      d = 32'h8040_2010 + 32'h1111_1111 * k;
      push_beat(d, k[1], model(d, k[1]));
    end
    run_stream(4, 2, 3, 0, "bubbles");

    // Async reset with two beats in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1122_3344;
    bus.in_inv    = 1'b0;
    @(negedge clk);
    bus.in_data   = 32'h5566_7788;
    bus.in_inv    = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    check("full out_valid", bus.out_valid, 1'b1);
    check("full in_ready", bus.in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", bus.out_valid, 1'b0);
    check("async rst busy", bus.busy, 1'b0);
    check("async rst out_data", bus.out_data, 32'h0);
    check("async rst out_inv", bus.out_inv, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    push_beat(32'h5301_00FF, 1'b0, 32'hED7C_6316);
    run_stream(1000, 0, 0, 3, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
